// File: rtl/transpose_buffer_8x8.sv
// -----------------------------------------------------------------------------
// transpose_buffer_8x8
//
// Transpose store between the row and column passes of the 8x8 integer
// transform. Row-pass results arrive one per handshake in row-major order and
// are written into a block bank. Once a bank holds a full N x N block it is
// replayed in column-major order towards the column-pass multiplier bank.
//
// Configuration macro:
//   TRANSPOSE_PINGPONG_EN  defined   : two banks, one fills while the other
//                                      drains (1 sample/cycle sustained).
//                          undefined : single bank, fill then drain.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream sample valid
//   in_ready   write bank is empty and can take a sample
//   in_data    row-pass sample, row-major order
//   out_valid  read bank is full, out_data is valid
//   out_ready  downstream accepts the presented sample
//   out_data   stored sample, column-major order (0 while out_valid = 0)
//   out_sop    first sample of a block (col0,row0), 0 while out_valid = 0
//   out_eoc    last sample of each column (row N-1), 0 while out_valid = 0
// -----------------------------------------------------------------------------
module transpose_buffer_8x8 #(
  parameter int DATA_W = 25,
  parameter int N      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eoc
);

  localparam int BLK   = N * N;
  localparam int LOG_N = $clog2(N);
  localparam int IDX_W = 2 * LOG_N;
`ifdef TRANSPOSE_PINGPONG_EN
  localparam int NUM_BANKS = 2;
`else
  localparam int NUM_BANKS = 1;
`endif
  localparam int MEM_DEPTH = NUM_BANKS * BLK;
  localparam int MEM_AW    = $clog2(MEM_DEPTH);

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  logic [IDX_W-1:0]     wr_idx_r;
  logic [IDX_W-1:0]     rd_idx_r;
  bank_state_e          bank_state_r      [NUM_BANKS];
  bank_state_e          bank_state_next_s [NUM_BANKS];
  logic [NUM_BANKS-1:0] wr_sel_s;
  logic [NUM_BANKS-1:0] rd_sel_s;
  logic                 wr_bank_full_s;
  logic                 rd_bank_full_s;
  logic                 in_hs_s;
  logic                 out_hs_s;
  logic                 wr_last_s;
  logic                 rd_last_s;
  logic [MEM_AW-1:0]    wr_addr_s;
  logic [MEM_AW-1:0]    rd_addr_s;

  // Sample storage; deliberately not reset, a bank is only read once full.
  logic [DATA_W-1:0]    mem_r [MEM_DEPTH];

  assign in_hs_s   = in_valid & in_ready;
  assign out_hs_s  = out_valid & out_ready;
  assign wr_last_s = (wr_idx_r == IDX_W'(BLK - 1));
  assign rd_last_s = (rd_idx_r == IDX_W'(BLK - 1));

`ifdef TRANSPOSE_PINGPONG_EN
  logic wr_bank_r;
  logic rd_bank_r;

  // Bank pointers: each side moves to the other bank after its index-63 handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_r <= 1'b0;
      rd_bank_r <= 1'b0;
    end else begin
      if (in_hs_s && wr_last_s) begin
        wr_bank_r <= ~wr_bank_r;
      end
      if (out_hs_s && rd_last_s) begin
        rd_bank_r <= ~rd_bank_r;
      end
    end
  end

  // One-hot bank selects: bit b set when the pointer addresses bank b.
  assign wr_sel_s       = {wr_bank_r, ~wr_bank_r};
  assign rd_sel_s       = {rd_bank_r, ~rd_bank_r};
  assign wr_bank_full_s = (bank_state_r[wr_bank_r] == BANK_FULL);
  assign rd_bank_full_s = (bank_state_r[rd_bank_r] == BANK_FULL);

  // Row-major write address is the index itself; the read address swaps the
  // row/col fields so the index walks down columns.
  assign wr_addr_s = {wr_bank_r, wr_idx_r};
  assign rd_addr_s = {rd_bank_r, rd_idx_r[LOG_N-1:0], rd_idx_r[IDX_W-1:LOG_N]};
`else
  assign wr_sel_s       = 1'b1;
  assign rd_sel_s       = 1'b1;
  assign wr_bank_full_s = (bank_state_r[0] == BANK_FULL);
  assign rd_bank_full_s = (bank_state_r[0] == BANK_FULL);

  // Row-major write address is the index itself; the read address swaps the
  // row/col fields so the index walks down columns.
  assign wr_addr_s = wr_idx_r;
  assign rd_addr_s = {rd_idx_r[LOG_N-1:0], rd_idx_r[IDX_W-1:LOG_N]};
`endif

  assign in_ready  = ~wr_bank_full_s;
  assign out_valid = rd_bank_full_s;

  // Bank state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_state_r[b] <= BANK_EMPTY;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_state_r[b] <= bank_state_next_s[b];
      end
    end
  end

  // Bank next state: fill completes on the index-63 write, drain completes on
  // the index-63 read. A bank is never written and read in the same state.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_state_next_s[b] = bank_state_r[b];
      case (bank_state_r[b])
        BANK_EMPTY: begin
          if (in_hs_s && wr_last_s && wr_sel_s[b]) begin
            bank_state_next_s[b] = BANK_FULL;
          end else begin
            bank_state_next_s[b] = BANK_EMPTY;
          end
        end
        BANK_FULL: begin
          if (out_hs_s && rd_last_s && rd_sel_s[b]) begin
            bank_state_next_s[b] = BANK_EMPTY;
          end else begin
            bank_state_next_s[b] = BANK_FULL;
          end
        end
        default: begin
          bank_state_next_s[b] = BANK_EMPTY;
        end
      endcase
    end
  end

  // Write index: advances on every input handshake, wraps naturally at 63.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_r <= {IDX_W{1'b0}};
    end else if (in_hs_s) begin
      wr_idx_r <= wr_idx_r + IDX_W'(1);
    end
  end

  // Read index: advances on every output handshake, wraps naturally at 63.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx_r <= {IDX_W{1'b0}};
    end else if (out_hs_s) begin
      rd_idx_r <= rd_idx_r + IDX_W'(1);
    end
  end

  // Sample array write port.
  always_ff @(posedge clk) begin
    if (in_hs_s) begin
      mem_r[wr_addr_s] <= in_data;
    end
  end

  // Presented sample and framing flags, all forced low while no block is ready.
  always_comb begin
    out_data = {DATA_W{1'b0}};
    out_sop  = 1'b0;
    out_eoc  = 1'b0;
    if (rd_bank_full_s) begin
      out_data = mem_r[rd_addr_s];
      out_sop  = (rd_idx_r == {IDX_W{1'b0}});
      out_eoc  = (rd_idx_r[LOG_N-1:0] == LOG_N'(N - 1));
    end else begin
      out_data = {DATA_W{1'b0}};
      out_sop  = 1'b0;
      out_eoc  = 1'b0;
    end
  end

endmodule

// File: tb/tb_transpose_buffer_8x8.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_transpose_buffer_8x8
// Bench for transpose_buffer_8x8. The reference keeps the pending output
// stream as a queue of whole blocks, already transposed from the input order.
// -----------------------------------------------------------------------------
module tb_transpose_buffer_8x8;

  localparam int DATA_W = 25;
  localparam int N      = 8;
  localparam int BLK    = N * N;
`ifdef TRANSPOSE_PINGPONG_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sop;
  logic              out_eoc;

  int n_checks = 0;
  int n_errors = 0;
  int src_q[$];   // values still to be offered upstream
  int blk_q[$];   // partially received block, row-major
  int exp_q[$];   // expected output stream, column-major per block
  int bp_left = 0;

  always #5 clk = ~clk;

  transpose_buffer_8x8 #(
    .DATA_W(DATA_W),
    .N     (N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sop  (out_sop),
    .out_eoc  (out_eoc)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, check 1 ns later, update the model.
  task automatic step(input int in_pct, input int out_pct);
    int   held;
    int   pos;
    logic exp_valid;
    logic exp_ready;
    logic bp_now;
    @(negedge clk);
    held      = (exp_q.size() + BLK - 1) / BLK;
    pos       = (held > 0) ? (BLK - (exp_q.size() - BLK * (held - 1))) : 0;
    exp_valid = (held > 0);
    exp_ready = (held < CAP);
    if (src_q.size() > 0) begin
      in_valid = ($urandom_range(99) < in_pct);
      in_data  = DATA_W'(src_q[0]);
    end else begin
      in_valid = 1'b0;
      in_data  = '0;
    end
    out_ready = ($urandom_range(99) < out_pct);
    bp_now    = 1'b0;
    if (bp_left > 0 && exp_valid && pos == 10) begin
      out_ready = 1'b0;
      bp_now    = 1'b1;
      bp_left--;
    end
    #1;
    check_eq("in_ready", in_ready, exp_ready);
    check_eq("out_valid", out_valid, exp_valid);
    if (exp_valid) begin
      check_eq("out_data", out_data, exp_q[0]);
      check_eq("out_sop", out_sop, pos == 0);
      check_eq("out_eoc", out_eoc, (pos % N) == N - 1);
    end else begin
      check_eq("idle_data", out_data, 0);
      check_eq("idle_sop", out_sop, 0);
      check_eq("idle_eoc", out_eoc, 0);
    end
    if (bp_now) begin
      check_eq("bp_hold_data", out_data, 17);
    end
    if (exp_valid && out_ready) begin
      void'(exp_q.pop_front());
    end
    if (in_valid && exp_ready) begin
      blk_q.push_back(src_q.pop_front());
      if (blk_q.size() == BLK) begin
        for (int c = 0; c < N; c++) begin
          for (int r = 0; r < N; r++) begin
            exp_q.push_back(blk_q[r * N + c]);
          end
        end
        blk_q.delete();
      end
    end
  endtask

  task automatic run(input string name, input int in_pct, input int out_pct, input int budget);
    int cyc = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      step(in_pct, out_pct);
      cyc++;
    end
    check_eq({name, "_done"}, (src_q.size() == 0 && exp_q.size() == 0), 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_sop", out_sop, 0);
    check_eq("rst_out_eoc", out_eoc, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    repeat (10) step(0, 50);

    for (int k = 0; k < BLK; k++) src_q.push_back(k);
    run("single", 100, 100, 300);

    for (int k = 0; k < BLK; k++) src_q.push_back(k);
    bp_left = 5;
    run("backpressure", 100, 100, 400);
    check_eq("bp_stalls_used", bp_left, 0);

    for (int b = 0; b < 3; b++)
      for (int k = 0; k < BLK; k++) src_q.push_back(k + 100 * b);
    run("stream", 100, 100, 600);

    for (int k = 0; k < 4 * BLK; k++) src_q.push_back(int'($urandom & 32'h01FF_FFFF));
    run("random", 70, 60, 3000);

    // One full block held plus a partial one, then reset in the middle of a cycle.
    for (int k = 0; k < BLK + 30; k++) src_q.push_back(300 + k);
    repeat (BLK + 30) step(100, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    check_eq("midrst_out_data", out_data, 0);
    check_eq("midrst_out_sop", out_sop, 0);
    src_q.delete();
    blk_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < BLK; k++) src_q.push_back(500 + k);
    run("post_reset", 100, 100, 300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/transpose_buffer_8x8.md
# transpose_buffer_8x8

Block-level transpose store between the row and column passes of the 8x8 integer transform. It accepts one 25-bit row-pass result per handshake in row-major order and stores it. Once a full 8x8 block is held, it replays the block in column-major order to the column-pass constant-multiplier bank.

## Interface
Parameters:
- DATA_W, 25, sample width; matches the multiplier datapath.
- N, 8, block dimension; block holds N*N = 64 samples.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low. One clock domain; reset is asynchronous and active-low.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  buffer can accept a sample this cycle.
- in_data  in  DATA_W  row-pass sample, row-major (row0 col0..col7, row1 ...).
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the sample.
- out_data  out  DATA_W  stored sample, column-major.
- out_sop  out  1  high with the first sample of a block (col0, row0).
- out_eoc  out  1  high with the last sample of each column (row7).

## Operation
- Storage is a register array of 64 x DATA_W per bank. The array has no reset.
- Input write counter wr_idx, 6 bits:
  - An input handshake is in_valid & in_ready.
  - Each input handshake stores in_data at (row = wr_idx[5:3], col = wr_idx[2:0]) in the write bank, then increments wr_idx.
  - wr_idx wraps 63 -> 0.
- Output read counter rd_idx, 6 bits:
  - The presented sample is (row = rd_idx[2:0], col = rd_idx[5:3]) of the read bank.
  - An output handshake is out_valid & out_ready; each one increments rd_idx, wrapping 63 -> 0.
- Bank state, one per bank:
  - EMPTY -> FULL on the input handshake that writes index 63 into that bank.
  - FULL -> EMPTY on the output handshake that reads index 63 from that bank.
- in_ready = (write bank is EMPTY).
- out_valid = (read bank is FULL).
- out_data, out_sop and out_eoc are combinational from rd_idx and the array. All three are forced to 0 when out_valid = 0.
  - out_sop = (rd_idx == 0).
  - out_eoc = (rd_idx[2:0] == 7).
- Data is passed bit-exact; no arithmetic, no sign handling.
- out_data may change only after an output handshake or a bank state change, never while out_valid = 1 and out_ready = 0.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0, out_data = 0, out_sop = 0, out_eoc = 0.
  - wr_idx = 0, rd_idx = 0, all banks EMPTY, both bank pointers = bank 0.
- Latency: first output sample (out_sop) is valid the cycle after the 64th input handshake of a block.
- A bank freed by its last output handshake accepts input in the next cycle.
- The write and read sides operate independently in the same cycle whenever they address different banks.
- Back-pressure: out_ready = 0 holds rd_idx and all outputs. in_valid = 0 holds wr_idx.
- Reset asserted mid-block discards all partial and full blocks. Outputs return to reset values asynchronously.

## Configuration
- TRANSPOSE_PINGPONG_EN defined:
  - Two banks. The write bank pointer toggles after each input index-63 handshake; the read bank pointer toggles after each output index-63 handshake.
  - While one bank drains, the other fills. Sustained throughput is 1 sample/cycle with both sides always ready.
- Undefined:
  - Single bank. in_ready = 0 from the cycle after the 64th write until the cycle after the 64th read.
  - Throughput is 64 in, then 64 out; at least 128 cycles per block.

## Test plan
- Reset then idle: in_ready = 1, out_valid = 0, out_data = 0 for 10 cycles.
- Single block:
  - Stimulus: drive in_data = k for k = 0..63 with out_ready = 1.
  - Required: output sequence 0, 8, 16 .. 56, 1, 9 .. 63.
  - Required: out_sop on the first sample only; out_eoc on values 56, 57 .. 63.
  - Required: first out_valid one cycle after input 63.
- Back-pressure:
  - Stimulus: hold out_ready = 0 for 5 cycles at rd_idx = 10.
  - Required: out_data stays 17 and out_valid stays 1; the stream resumes with 25.
- Streaming, macro defined:
  - Stimulus: 3 back-to-back blocks (values k, k+100, k+200) with in_valid and out_ready = 1.
  - Required: in_ready never drops after reset; all 192 outputs are correctly transposed.
- Streaming, macro undefined:
  - Stimulus: same as the previous scenario.
  - Required: in_ready = 0 for exactly the 64 drain cycles of each block.
- Mid-block reset:
  - Stimulus: assert rst_n = 0 after 30 inputs.
  - Required: out_valid = 0. A following block of values 500 + k outputs 500, 508 .. with no stale data.
